uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- 8N1 UART transmitter; produces the serial line that the team's UART receiver samples.
- Accepts bytes over a valid/ready handshake into a small FIFO.
- Serialises each byte as: start bit, 8 data bits LSB first, one stop bit.
- Bit timing comes from a free-running divider matched to the receiver's baud rate.

Parameters:
- CLKS_PER_BIT, 1252, clock cycles per serial bit; must be >= 2. The receiver's bit clock toggles every 626 cycles, giving a 1252-cycle period.
- FIFO_DEPTH, 4, byte entries in the input FIFO; must be a power of two, >= 2.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- tx_data  input  8  byte to send; sampled when tx_valid && tx_ready.
- tx_valid  input  1  upstream has a byte.
- tx_ready  output  1  FIFO not full. Combinational from the FIFO count.
- tx  output  1  serial line; idle high. Registered.
- busy  output  1  high when a frame is in progress or the FIFO is non-empty. Registered.

Behaviour:
- Reset: one clock with reset==0.
  - tx=1, busy=0, state=IDLE.
  - FIFO count=0, read/write pointers=0, bit counter=0, bit index=0.
  - tx_ready=1 from the first cycle after reset.
  - Reset mid-frame aborts the frame; tx is high after that edge. FIFO contents are discarded.
- FIFO:
  - Push on tx_valid && tx_ready.
  - Pop only from the state machine when count != 0.
  - Simultaneous push and pop: count is unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
  - When full, tx_ready=0; tx_valid is then ignored and no data is lost or overwritten.
- States: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count!=0, pop the head into an 8-bit shift register, clear the bit counter, go to START, and drive tx<=0 on the same edge.
  - START: hold tx=0 for CLKS_PER_BIT cycles. At terminal count, go to DATA with bit index 0 and tx<=shift[0].
  - DATA: each bit is held CLKS_PER_BIT cycles. At terminal count:
    - if index<7: index+1, tx<=next bit (LSB first);
    - if index==7: go to STOP with tx<=1.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. At terminal count:
    - if count!=0: pop, load the shift register, go directly to START with tx<=0 (no idle gap);
    - otherwise go to IDLE.
- Bit counter: runs 0..CLKS_PER_BIT-1; terminal count at CLKS_PER_BIT-1, then wraps to 0. Width is $clog2(CLKS_PER_BIT).
- Latency: byte pushed at edge N into an empty FIFO while IDLE → tx low after edge N+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Back-to-back frames are contiguous: the stop bit is exactly CLKS_PER_BIT cycles and is followed by the next start bit.
- busy rises the edge after the first push. It falls at the edge where STOP returns to IDLE with the FIFO empty.
- tx_data is captured at push time; later changes on tx_data do not affect queued bytes.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset hold then release, no traffic → tx=1, busy=0, tx_ready=1 for 100 cycles.
- Push 8'hA5 at cycle N → tx low at N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1 for 4 cycles. busy falls at N+41.
- Push 8'h00 and 8'hFF on consecutive cycles → two 40-cycle frames with no gap. Second frame starts on the cycle after the first stop bit ends.
- Push 6 bytes with tx_valid held high from idle → tx_ready drops once 4 bytes are queued (head already popped, so 5 accepted before stall). Remaining bytes are accepted as frames drain. All 6 bytes appear on tx in order.
- Assert reset during DATA bit 3 of 8'h3C with 2 bytes queued → tx=1 the next cycle, busy=0, FIFO empty. No further frames after release.
- Push 8'h55 each time tx_ready is high, with a receiver model sampling mid-bit → every decoded byte equals 8'h55 and each stop bit reads 1.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a small input FIFO.
//
// Bytes are accepted on a valid/ready handshake into a FIFO. Each byte
// goes out as one start bit (0), eight data bits (LSB first) and one stop
// bit (1). Every bit lasts CLKS_PER_BIT clocks, which matches the team's
// UART receiver. Frames that are queued back to back are sent with no idle
// gap between them.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   FIFO_DEPTH    FIFO entries (power of two, >= 2)
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   synchronous, active-low reset
//   tx_data   in   [7:0] byte to send, captured when tx_valid && tx_ready
//   tx_valid  in   upstream has a byte
//   tx_ready  out  FIFO not full (combinational from the FIFO count)
//   tx        out  serial line, idle high (registered)
//   busy      out  frame in progress or FIFO non-empty (registered)
module uart_tx #(
    parameter int CLKS_PER_BIT = 1252,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             bit_done;
    logic             push;
    logic             pop;

    assign tx_ready = (count != FIFO_FULL);
    assign push     = tx_valid && tx_ready;
    assign bit_done = (bit_cnt == BIT_LAST);
    // The FSM takes the head either from idle or at the end of a stop bit,
    // so queued frames follow each other without an idle gap.
    assign pop      = (count != '0) &&
                      ((state == IDLE) || ((state == STOP) && bit_done));

    // FIFO storage holds data only; it needs no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally since the depth
    // is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Framing state machine with registered line output.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            bit_cnt <= '0;
            bit_idx <= '0;
        end else begin
            bit_cnt <= bit_done ? '0 : bit_cnt + 1'b1;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    tx      <= 1'b1;
                    if (pop) begin
                        shift <= fifo_mem[rd_ptr];
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[bit_idx + 3'd1];
                        end
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            shift <= fifo_mem[rd_ptr];
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed testbench for uart_tx with CLKS_PER_BIT=4 and
// FIFO_DEPTH=4. Expected line levels are derived from the 8N1 frame format;
// a mid-bit receiver model decodes the line for the streaming tests.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    logic       mon_en = 1'b0;
    logic [9:0] rx_q [$];   // {start_mid, stop, data}

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Samples the current cycle and the following 39, one bit period per check.
    task automatic expect_frame(input string tag, input logic [7:0] b);
        logic [3:0] win;
        logic       e;
        for (int i = 0; i < 10; i++) begin
            e = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
            for (int k = 0; k < CPB; k++) begin
                win[k] = tx;
                tick();
            end
            check($sformatf("%s_bit%0d", tag, i), {28'd0, win}, {28'd0, {4{e}}});
        end
    endtask

    // Receiver model: detects the start bit, then samples in the middle of
    // each bit period.
    initial begin : rx_model
        logic       s;
        logic       st;
        logic [7:0] d;
        forever begin
            tick();
            if (mon_en && tx === 1'b0) begin
                repeat (CPB / 2) tick();
                s = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) tick();
                    d[i] = tx;
                end
                repeat (CPB) tick();
                st = tx;
                rx_q.push_back({s, st, d});
                repeat (CPB / 2 - 1) tick();
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int         bad;
        int         idx;
        int         stall_idx;
        int         cyc;
        int         pushed;
        logic       acc;
        logic [7:0] b6 [6];

        // Reset state
        reset    = 1'b0;
        tx_valid = 1'b0;
        repeat (2) tick();
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_ready", tx_ready, 1);
        reset = 1'b1;
        bad = 0;
        repeat (100) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) bad++;
        end
        check("idle_quiet_cycles_bad", bad, 0);

        // Single frame 8'hA5
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();                       // push edge N
        tx_valid = 1'b0;
        check("a5_still_idle_at_N", tx, 1);
        tick();                       // edge N+1
        check("a5_start_at_N1", tx, 0);
        check("a5_busy_rise", busy, 1);
        expect_frame("a5", 8'hA5);    // ends after edge N+41
        check("a5_busy_fall_N41", busy, 0);
        check("a5_idle_tx", tx, 1);

        // Back-to-back 8'h00 then 8'hFF
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        tick();
        tx_data  = 8'hFF;
        tick();
        tx_valid = 1'b0;
        expect_frame("b2b_00", 8'h00);
        expect_frame("b2b_ff", 8'hFF);
        check("b2b_busy_fall", busy, 0);

        // Six bytes with tx_valid held high
        b6[0] = 8'h11; b6[1] = 8'h22; b6[2] = 8'h33;
        b6[3] = 8'h44; b6[4] = 8'h55; b6[5] = 8'h66;
        rx_q.delete();
        mon_en    = 1'b1;
        idx       = 0;
        stall_idx = -1;
        cyc       = 0;
        while (idx < 6 && cyc < 1000) begin
            tx_data  = b6[idx];
            tx_valid = 1'b1;
            if (tx_ready === 1'b0 && stall_idx < 0) stall_idx = idx;
            acc = tx_ready;
            tick();
            cyc++;
            if (acc) idx++;
        end
        tx_valid = 1'b0;
        check("fill_stall_after_accepted", stall_idx, 5);
        check("fill_all_accepted", idx, 6);
        cyc = 0;
        while (rx_q.size() < 6 && cyc < 600) begin
            tick();
            cyc++;
        end
        check("fill_rx_count", rx_q.size(), 6);
        for (int i = 0; i < rx_q.size() && i < 6; i++) begin
            check($sformatf("fill_data%0d", i), rx_q[i][7:0], b6[i]);
            check($sformatf("fill_stop%0d", i), rx_q[i][8], 1);
            check($sformatf("fill_start%0d", i), rx_q[i][9], 0);
        end
        mon_en = 1'b0;
        cyc = 0;
        while (busy !== 1'b0 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("fill_busy_fall", busy, 0);

        // Reset during data bit 3 of 8'h3C with two bytes queued
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick();                       // edge N
        tx_data  = 8'h11;
        tick();                       // edge N+1, frame starts
        tx_data  = 8'h22;
        tick();                       // edge N+2
        tx_valid = 1'b0;
        repeat (15) tick();           // after edge N+17: data bit 3
        check("abort_in_bit3", tx, 1);
        check("abort_busy_before", busy, 1);
        tick();                       // after edge N+18
        reset = 1'b0;
        tick();                       // reset edge N+19
        check("abort_tx_high", tx, 1);
        check("abort_busy_low", busy, 0);
        check("abort_ready", tx_ready, 1);
        reset = 1'b1;
        bad = 0;
        repeat (100) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("abort_no_frames_after", bad, 0);

        // Stream of 8'h55 whenever tx_ready is high
        rx_q.delete();
        mon_en = 1'b1;
        pushed = 0;
        cyc    = 0;
        while (pushed < 8 && cyc < 2000) begin
            tx_data  = 8'h55;
            tx_valid = 1'b1;
            acc = tx_ready;
            tick();
            cyc++;
            if (acc) pushed++;
        end
        tx_valid = 1'b0;
        cyc = 0;
        while (rx_q.size() < 8 && cyc < 800) begin
            tick();
            cyc++;
        end
        check("s55_rx_count", rx_q.size(), 8);
        for (int i = 0; i < rx_q.size() && i < 8; i++) begin
            check($sformatf("s55_data%0d", i), rx_q[i][7:0], 8'h55);
            check($sformatf("s55_stop%0d", i), rx_q[i][8], 1);
        end
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
